// File: rtl/word_byte_packer_if.sv
// rtl/word_byte_packer_if.sv - byte-in / packed-word-out handshake bundle
interface word_byte_packer_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [1:0]  out_be;
  logic        out_last;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_be, out_last
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_be, out_last
  );
endinterface

// File: rtl/word_byte_packer.sv
// rtl/word_byte_packer.sv - packs a byte stream into 16-bit words with byte enables
module word_byte_packer #(
  parameter bit             HIGH_FIRST = 1'b1,
  parameter logic [7:0]     PAD        = 8'h00,
  parameter int unsigned    CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  word_byte_packer_if.slave    bus,
  output logic [CNT_W-1:0]     word_cnt
);
  localparam logic [0:0] S_EMPTY = 1'b0;
  localparam logic [0:0] S_HALF  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [7:0]       hold_q, hold_d;
  logic             out_valid_q, out_valid_d;
  logic [15:0]      out_data_q, out_data_d;
  logic [1:0]       out_be_q, out_be_d;
  logic             out_last_q, out_last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic slot_free;
  logic in_ready;
  logic accept;
  logic handoff;

  assign slot_free = !out_valid_q || bus.out_ready;
  // A lone last byte in EMPTY produces a word, so it must wait for a free slot.
  assign in_ready  = (state_q == S_HALF) ? slot_free : (!bus.in_last || slot_free);
  assign accept    = bus.in_valid && in_ready;
  assign handoff   = out_valid_q && bus.out_ready;

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_be_d    = out_be_q;
    out_last_d  = out_last_q;
    cnt_d       = cnt_q;

    if (handoff) begin
      out_valid_d = 1'b0;
      cnt_d       = cnt_q + 1'b1;
    end

    if (accept) begin
      if (state_q == S_EMPTY) begin
        if (!bus.in_last) begin
          hold_d  = bus.in_data;
          state_d = S_HALF;
        end else begin
          out_valid_d = 1'b1;
          out_last_d  = 1'b1;
          out_data_d  = HIGH_FIRST ? {bus.in_data, PAD} : {PAD, bus.in_data};
          out_be_d    = HIGH_FIRST ? 2'b10 : 2'b01;
        end
      end else begin
        out_valid_d = 1'b1;
        out_last_d  = bus.in_last;
        out_data_d  = HIGH_FIRST ? {hold_q, bus.in_data} : {bus.in_data, hold_q};
        out_be_d    = 2'b11;
        state_d     = S_EMPTY;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_EMPTY;
      hold_q      <= 8'h00;
      out_valid_q <= 1'b0;
      out_data_q  <= 16'h0000;
      out_be_q    <= 2'b00;
      out_last_q  <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_be_q    <= out_be_d;
      out_last_q  <= out_last_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_be    = out_be_q;
  assign bus.out_last  = out_last_q;
  assign word_cnt      = cnt_q;
endmodule

// File: tb/tb_word_byte_packer.sv
// tb/tb_word_byte_packer.sv - three packer configurations driven by one shared byte stream
module tb_word_byte_packer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] in_data = 8'h00;
  bit         rand_rdy = 1'b0;

  always #5 clk = ~clk;

  word_byte_packer_if ia ();
  word_byte_packer_if ib ();
  word_byte_packer_if ic ();

  assign ia.in_valid = in_valid;  assign ia.in_data = in_data;
  assign ia.in_last = in_last;    assign ia.out_ready = out_ready;
  assign ib.in_valid = in_valid;  assign ib.in_data = in_data;
  assign ib.in_last = in_last;    assign ib.out_ready = out_ready;
  assign ic.in_valid = in_valid;  assign ic.in_data = in_data;
  assign ic.in_last = in_last;    assign ic.out_ready = out_ready;

  logic [15:0] cnt_a, cnt_b;
  logic [3:0]  cnt_c;

  word_byte_packer #(.HIGH_FIRST(1'b1), .PAD(8'hEE), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ia.slave), .word_cnt(cnt_a));
  word_byte_packer #(.HIGH_FIRST(1'b0), .PAD(8'hA5), .CNT_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ib.slave), .word_cnt(cnt_b));
  word_byte_packer #(.HIGH_FIRST(1'b1), .PAD(8'h00), .CNT_W(4)) dut_c (
    .clk(clk), .rst_n(rst_n), .bus(ic.slave), .word_cnt(cnt_c));

  logic        ov [3];
  logic        ir [3];
  logic [15:0] od [3];
  logic [1:0]  ob [3];
  logic        ol [3];
  assign ov[0] = ia.out_valid; assign ov[1] = ib.out_valid; assign ov[2] = ic.out_valid;
  assign ir[0] = ia.in_ready;  assign ir[1] = ib.in_ready;  assign ir[2] = ic.in_ready;
  assign od[0] = ia.out_data;  assign od[1] = ib.out_data;  assign od[2] = ic.out_data;
  assign ob[0] = ia.out_be;    assign ob[1] = ib.out_be;    assign ob[2] = ic.out_be;
  assign ol[0] = ia.out_last;  assign ol[1] = ib.out_last;  assign ol[2] = ic.out_last;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a word is a first byte, optional second byte and a last flag;
  // lane placement and padding are derived per configuration only when compared.
  typedef struct packed {
    logic [7:0] f;
    logic [7:0] s;
    logic       pair;
    logic       last;
  } word_t;

  word_t       q[$];
  bit          held = 1'b0;
  logic [7:0]  held_b = 8'h00;
  int unsigned n_words = 0;

  function automatic logic [15:0] exp_data(input int k, input word_t w);
    bit         hf  = (k != 1);
    logic [7:0] pad = (k == 0) ? 8'hEE : (k == 1) ? 8'hA5 : 8'h00;
    if (w.pair) return hf ? {w.f, w.s} : {w.s, w.f};
    return hf ? {w.f, pad} : {pad, w.f};
  endfunction

  function automatic logic [1:0] exp_be(input int k, input word_t w);
    if (w.pair) return 2'b11;
    return (k != 1) ? 2'b10 : 2'b01;
  endfunction

  always @(negedge clk) begin : model
    logic slot;
    logic exp_rdy;
    if (!rst_n) begin
      q.delete();
      held = 1'b0;
      n_words = 0;
    end else begin
      slot    = (q.size() == 0) || out_ready;
      exp_rdy = held ? slot : (!in_last || slot);
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("in_ready[%0d]", k), ir[k], exp_rdy);
        chk($sformatf("out_valid[%0d]", k), ov[k], q.size() != 0);
        if (q.size() != 0) begin
          chk($sformatf("out_data[%0d]", k), od[k], exp_data(k, q[0]));
          chk($sformatf("out_be[%0d]", k), ob[k], exp_be(k, q[0]));
          chk($sformatf("out_last[%0d]", k), ol[k], q[0].last);
        end
      end
      chk("word_cnt_a", cnt_a, n_words[15:0]);
      chk("word_cnt_b", cnt_b, n_words[15:0]);
      chk("word_cnt_c", cnt_c, n_words[3:0]);
      if (q.size() != 0 && out_ready) begin
        void'(q.pop_front());
        n_words++;
      end
      if (in_valid && ia.in_ready) begin
        if (!held && !in_last) begin
          held   = 1'b1;
          held_b = in_data;
        end else if (!held) begin
          q.push_back('{f: in_data, s: 8'h00, pair: 1'b0, last: 1'b1});
        end else begin
          q.push_back('{f: held_b, s: in_data, pair: 1'b1, last: in_last});
          held = 1'b0;
        end
      end
    end
  end

  always begin
    @(posedge clk);
    #1;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  end

  task automatic send(input logic [7:0] b, input bit l);
    int budget = 0;
    in_valid = 1'b1;
    in_data  = b;
    in_last  = l;
    forever begin
      @(negedge clk);
      if (ia.in_ready) break;
      budget++;
      if (budget > 200) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: byte %0h never accepted", b);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_out_valid", ov[k], 1'b0);
      chk("rst_out_data", od[k], 16'h0000);
      chk("rst_out_be", ob[k], 2'b00);
      chk("rst_out_last", ol[k], 1'b0);
    end
    chk("rst_cnt_a", cnt_a, 16'd0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", ia.in_ready, 1'b1);

    out_ready = 1'b1;
    send(8'hAA, 1'b0);
    send(8'h55, 1'b0);
    chk("pair_hi_data", ia.out_data, 16'hAA55);
    chk("pair_hi_be", ia.out_be, 2'b11);
    chk("pair_hi_last", ia.out_last, 1'b0);
    chk("pair_lo_data", ib.out_data, 16'h55AA);
    idle(1);
    chk("pair_cnt", cnt_a, 16'd1);

    send(8'h12, 1'b0);
    send(8'h34, 1'b1);
    chk("lo_first_data", ib.out_data, 16'h3412);
    chk("lo_first_last", ib.out_last, 1'b1);
    idle(1);

    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    chk("odd_w0_data", ia.out_data, 16'h0102);
    send(8'h03, 1'b1);
    chk("odd_w1_data", ia.out_data, 16'h03EE);
    chk("odd_w1_be", ia.out_be, 2'b10);
    chk("odd_w1_last", ia.out_last, 1'b1);
    chk("odd_w1_lo_data", ib.out_data, 16'hA503);
    chk("odd_w1_lo_be", ib.out_be, 2'b01);
    idle(1);

    out_ready = 1'b0;
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    in_valid = 1'b1;
    in_data  = 8'h44;
    in_last  = 1'b0;
    @(negedge clk);
    chk("bp_in_ready_low", ia.in_ready, 1'b0);
    repeat (3) @(negedge clk);
    chk("bp_hold_data", ia.out_data, 16'h1122);
    chk("bp_hold_valid", ia.out_valid, 1'b1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(8'h44, 1'b0);
    chk("bp_resume_data", ia.out_data, 16'h3344);
    idle(1);
    chk("bp_cnt", cnt_a, 16'd6);

    out_ready = 1'b0;
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    send(8'h03, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", ia.out_valid, 1'b0);
    chk("arst_data", ia.out_data, 16'h0000);
    chk("arst_cnt", cnt_a, 16'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    send(8'hC0, 1'b0);
    send(8'hDE, 1'b0);
    chk("arst_next_data", ia.out_data, 16'hC0DE);
    idle(2);

    #2;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 34; i++) send(8'(i * 7 + 1), 1'b0);
    idle(2);
    chk("wrap_cnt_c", cnt_c, 4'd1);
    chk("wrap_cnt_a", cnt_a, 16'd17);

    rand_rdy = 1'b1;
    repeat (400) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      send(8'($urandom), $urandom_range(0, 3) == 0);
    end
    rand_rdy = 1'b0;
    #1;
    out_ready = 1'b1;
    send(8'h5C, 1'b1);
    idle(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/word_byte_packer.md
Name: word_byte_packer

Overview:
- Assembles a byte stream into 16-bit packed words of the form {high[7:0], low[7:0]}, with a valid/ready handshake on both sides.
- Sits directly upstream of the packed-struct word consumers; each output word carries per-byte enables so the consumer can do partial (byte-lane) writes of word.high / word.low.
- A packet-end marker (in_last) forces out a partially filled word with the empty lane padded.

Parameters:
- HIGH_FIRST, 1: 1 = first byte of a pair goes to high [15:8]; 0 = first byte goes to low [7:0].
- PAD, 8'h00: value driven on an unfilled byte lane of a partial word.
- CNT_W, 16: width of the emitted-word counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  byte present on in_data
- in_ready  output  1  block accepts byte this cycle
- in_data  input  8  byte payload
- in_last  input  1  byte is last of packet; qualified by in_valid
- out_valid  output  1  word present on out_data
- out_ready  input  1  consumer takes word this cycle
- out_data  output  16  packed word {high, low}
- out_be  output  2  byte enables; [1] = high lane valid, [0] = low lane valid
- out_last  output  1  word ends a packet
- word_cnt  output  CNT_W  number of words handed off (out_valid && out_ready)

Behaviour:
- Reset (rst_n low, async):
  - state = EMPTY; holding byte = 8'h00.
  - out_valid = 0, out_data = 16'h0000, out_be = 2'b00, out_last = 0, word_cnt = 0.
  - in_ready is combinational and reads 1 in EMPTY once reset deasserts.
- Reset mid-operation discards any held byte and any pending output word; no word is emitted for it.
- Byte accept = in_valid && in_ready. Word handoff = out_valid && out_ready.
- slot_free = !out_valid || out_ready. The output register is single-entry; same-cycle handoff and reload is allowed.
- State EMPTY (no byte held):
  - in_ready = 1 if in_last is low. If in_last is high, in_ready = slot_free, because a single-byte partial word is emitted.
  - Accept with in_last = 0: store byte, go to HALF.
  - Accept with in_last = 1: load output with the byte in the first lane and PAD in the other lane.
    - out_be = 2'b10 if HIGH_FIRST, else 2'b01.
    - out_last = 1; stay in EMPTY.
- State HALF (one byte held):
  - in_ready = slot_free.
  - Accept: load output with the held byte in the first lane and the new byte in the second lane.
  - out_be = 2'b11, out_last = in_last; go to EMPTY.
- Latency: out_valid rises on the clock edge that accepts the completing byte, so the word is visible the cycle after acceptance. Throughput is one word per two input cycles at sustained valid/ready.
- Output register:
  - Holds out_data, out_be and out_last stable while out_valid && !out_ready.
  - Clears out_valid on handoff unless reloaded in the same cycle.
- Held byte is never overwritten while in HALF.
- word_cnt increments by 1 per handoff and wraps modulo 2^CNT_W without saturation.
- Input protocol:
  - in_data and in_last may change freely while in_valid is low.
  - While in_valid is high and in_ready is low, the upstream holds in_data and in_last stable. The block relies on this and does not check it.
- No X is ever driven on out_data. Unfilled lanes are always PAD; this differs from the unwritten-bit X of a bare struct variable.

Test Plan:
- Reset, then bytes 8'hAA, 8'h55 with out_ready = 1, HIGH_FIRST = 1 -> one word: out_data = 16'hAA55, out_be = 2'b11, out_last = 0, word_cnt = 1.
- HIGH_FIRST = 0, bytes 8'h12, 8'h34 (in_last on 2nd) -> out_data = 16'h3412, out_be = 2'b11, out_last = 1.
- Odd packet 8'h01, 8'h02, 8'h03 (in_last on 3rd), PAD = 8'hEE, HIGH_FIRST = 1 -> words 16'h0102 (be 11, last 0) then 16'h03EE (be 10, last 1).
- Backpressure: out_ready = 0 with a word pending, stream 4 bytes -> 1st extra byte stored, in_ready = 0 in HALF. out_data stays stable until out_ready = 1, then streaming resumes with no loss or duplication; word_cnt = 2 at end.
- Async reset asserted while in HALF with a word pending -> out_valid = 0, out_data = 0, word_cnt = 0 immediately. Next bytes 8'hC0, 8'hDE -> 16'hC0DE.
- CNT_W = 4: 17 words handed off -> word_cnt wraps to 1; same-cycle handoff and reload yields back-to-back out_valid with no bubble.
